// File: rtl/bp_pkt_arbiter_pkg.sv
// Shared types and helpers for the BytePipe packet arbiter.
package bpArbPkg;

  localparam int unsigned GRANT_W         = 3;
  localparam logic [3:0]  HDR_TAG_DEFAULT = 4'hC;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HDR  = 2'd1,
    BODY = 2'd2
  } state_e;

  // Header byte: tag nibble, reserved zero bit, 3-bit source engine index.
  function automatic logic [7:0] hdr_byte(input logic [3:0] tag, input logic [GRANT_W-1:0] sel);
    return {tag, 1'b0, sel};
  endfunction

endpackage

// File: rtl/bp_pkt_arbiter_rr_pick.sv
// Combinational rotate-priority picker: first requester after i_ptr, wrapping mod N.
module rr_pick
  import bpArbPkg::*;
#(
  parameter int unsigned N = 2
) (
  input  logic [N-1:0]       i_req,
  input  logic [GRANT_W-1:0] i_ptr,
  output logic [GRANT_W-1:0] o_gnt,
  output logic               o_any
);

  int unsigned w_best;

  // Each requester's distance from the slot after i_ptr; the smallest distance wins.
  always_comb begin
    o_gnt  = '0;
    w_best = N;
    for (int unsigned j = 0; j < N; j++) begin
      if (i_req[j] && (((j + 2 * N - 32'(i_ptr) - 1) % N) < w_best)) begin
        w_best = (j + 2 * N - 32'(i_ptr) - 1) % N;
        o_gnt  = GRANT_W'(j);
      end
    end
  end

  assign o_any = |i_req;

endmodule

// File: rtl/bp_pkt_arbiter.sv
// Round-robin drain of per-engine packet FIFOs onto one BytePipe, each packet
// prefixed by a header byte naming its source engine.
module bp_pkt_arbiter
  import bpArbPkg::*;
#(
  parameter int unsigned N_ENGINE   = 2,
  parameter int unsigned PKT_NBYTES = 8,
  parameter logic [3:0]  HDR_TAG    = HDR_TAG_DEFAULT
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_cg,
  input  logic [N_ENGINE-1:0]   i_enable,
  input  logic [N_ENGINE*8-1:0] i_pktfifo_data,
  input  logic [N_ENGINE-1:0]   i_pktfifo_empty,
  output logic [N_ENGINE-1:0]   o_pktfifo_pop,
  output logic [7:0]            o_bp_data,
  output logic                  o_bp_valid,
  input  logic                  i_bp_ready,
  output logic                  o_busy,
  output logic [2:0]            o_grant
);

  localparam int unsigned CNT_W = $clog2(PKT_NBYTES + 1);

  state_e               r_state;
  state_e               w_state_nxt;
  logic [GRANT_W-1:0]   r_sel;
  logic [GRANT_W-1:0]   r_rr_ptr;
  logic [GRANT_W-1:0]   w_pick;
  logic [CNT_W-1:0]     r_cnt;
  logic                 w_any;
  logic                 w_xfer;
  logic                 w_last;
  logic [N_ENGINE-1:0]  w_req;
  logic [7:0]           w_head;
  logic                 w_head_empty;

  assign w_req = ~i_pktfifo_empty & i_enable;

  rr_pick #(
    .N (N_ENGINE)
  ) u_rr_pick (
    .i_req (w_req),
    .i_ptr (r_rr_ptr),
    .o_gnt (w_pick),
    .o_any (w_any)
  );

  // Head byte and empty flag of the granted FIFO.
  always_comb begin
    w_head       = '0;
    w_head_empty = 1'b1;
    for (int unsigned j = 0; j < N_ENGINE; j++) begin
      if (r_sel == GRANT_W'(j)) begin
        w_head       = i_pktfifo_data[j*8 +: 8];
        w_head_empty = i_pktfifo_empty[j];
      end
    end
  end

  assign w_last = (r_cnt == CNT_W'(PKT_NBYTES - 1));

  always_comb begin
    w_state_nxt   = r_state;
    o_bp_valid    = 1'b0;
    o_bp_data     = '0;
    o_pktfifo_pop = '0;
    w_xfer        = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (i_cg && w_any) w_state_nxt = HDR;
      end
      HDR: begin
        o_bp_valid = 1'b1;
        o_bp_data  = hdr_byte(HDR_TAG, r_sel);
        w_xfer     = i_bp_ready & i_cg;
        if (w_xfer) w_state_nxt = BODY;
      end
      BODY: begin
        o_bp_valid = ~w_head_empty;
        o_bp_data  = w_head;
        w_xfer     = ~w_head_empty & i_bp_ready & i_cg;
        for (int unsigned j = 0; j < N_ENGINE; j++) begin
          if (r_sel == GRANT_W'(j)) o_pktfifo_pop[j] = w_xfer;
        end
        if (w_xfer && w_last) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state  <= IDLE;
      r_sel    <= '0;
      r_rr_ptr <= GRANT_W'(N_ENGINE - 1);
      r_cnt    <= '0;
    end else if (i_cg) begin
      r_state <= w_state_nxt;
      if (r_state == IDLE && w_any) r_sel <= w_pick;
      if (r_state == HDR && w_xfer) r_cnt <= '0;
      if (r_state == BODY && w_xfer) begin
        if (w_last) begin
          r_cnt    <= '0;
          r_rr_ptr <= r_sel;
        end else begin
          r_cnt <= r_cnt + CNT_W'(1);
        end
      end
    end
  end

  assign o_busy  = (r_state != IDLE);
  assign o_grant = r_sel;

endmodule

// File: tb/tb_bp_pkt_arbiter.sv
// Directed bench for bp_pkt_arbiter: scenario table plus hand-written corner sequences.
module tb_bp_pkt_arbiter;

  localparam int unsigned N  = 2;
  localparam int unsigned PB = 8;

  logic           clk = 1'b0;
  logic           rst;
  logic           cg;
  logic [N-1:0]   enable;
  logic [N*8-1:0] fdata;
  logic [N-1:0]   empty;
  logic [N-1:0]   pop;
  logic [7:0]     bp_data;
  logic           bp_valid;
  logic           bp_ready;
  logic           busy;
  logic [2:0]     grant;

  always #5 clk = ~clk;

  bp_pkt_arbiter #(
    .N_ENGINE   (N),
    .PKT_NBYTES (PB),
    .HDR_TAG    (4'hC)
  ) dut (
    .i_clk           (clk),
    .i_rst           (rst),
    .i_cg            (cg),
    .i_enable        (enable),
    .i_pktfifo_data  (fdata),
    .i_pktfifo_empty (empty),
    .o_pktfifo_pop   (pop),
    .o_bp_data       (bp_data),
    .o_bp_valid      (bp_valid),
    .i_bp_ready      (bp_ready),
    .o_busy          (busy),
    .o_grant         (grant)
  );

  // FWFT FIFO stand-ins: main thread owns write pointers, pop process owns read pointers.
  logic [7:0] mem [N][256];
  logic [7:0] wr [N];
  logic [7:0] rd [N] = '{default: 8'd0};
  logic [N-1:0] pop_s = '0;

  for (genvar e = 0; e < N; e++) begin : g_fifo
    assign fdata[e*8 +: 8] = mem[e][rd[e]];
    assign empty[e]        = (rd[e] == wr[e]);
  end

  always @(negedge clk) pop_s = pop;
  always @(posedge clk) begin
    for (int e = 0; e < N; e++) if (pop_s[e]) rd[e] <= rd[e] + 8'd1;
  end

  // Output monitor: records transferred bytes and protocol violations.
  logic [7:0]  rx [$];
  int unsigned pops [N] = '{default: 0};
  int unsigned bad_pop = 0;
  int unsigned bad_hold = 0;
  logic        prev_hold = 1'b0;
  logic [7:0]  prev_data = 8'd0;

  always @(negedge clk) begin
    if (!rst) begin
      if (prev_hold && !(bp_valid && bp_data == prev_data)) bad_hold++;
      if (pop != '0) begin
        if (!$onehot(pop) || !(bp_valid && bp_ready && cg)) bad_pop++;
        for (int e = 0; e < N; e++) if (pop[e]) pops[e]++;
      end
      if (bp_valid && bp_ready && cg) rx.push_back(bp_data);
      prev_hold = bp_valid && !(bp_ready && cg);
      prev_data = bp_data;
    end else begin
      prev_hold = 1'b0;
    end
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) step();
  endtask

  task automatic push(input int e, input logic [7:0] b);
    mem[e][wr[e]] = b;
    wr[e] = wr[e] + 8'd1;
  endtask

  task automatic push_pkt(input int e, input logic [7:0] base);
    for (int i = 0; i < PB; i++) push(e, base + 8'(i));
  endtask

  function automatic logic [7:0] bval(input int e, input int p, input int i);
    return 8'(8'h10 + e * 8'h40 + p * 8 + i);
  endfunction

  task automatic do_reset();
    rst      = 1'b1;
    cg       = 1'b1;
    bp_ready = 1'b0;
    enable   = '0;
    step();
    step();
    for (int e = 0; e < N; e++) wr[e] = rd[e];
    step();
    rst = 1'b0;
  endtask

  task automatic wait_rx(input int unsigned b, input int unsigned n, input int unsigned budget);
    int unsigned c;
    c = 0;
    while ((rx.size() - b) < n && c < budget) begin
      step();
      c++;
    end
  endtask

  task automatic check_stream(input string name, input int unsigned b, input logic [7:0] exp[$]);
    check({name, "_len"}, 32'(rx.size() - b), 32'(exp.size()));
    for (int i = 0; i < exp.size(); i++) begin
      if (b + i < rx.size()) check($sformatf("%s_byte%0d", name, i), 32'(rx[b+i]), 32'(exp[i]));
    end
  endtask

  typedef struct {
    logic [1:0]  en;
    int          n0;
    int          n1;
    int          nhdr;
    logic [31:0] hdrs;   // header k at bits [k*8 +: 8]
  } vec_t;

  vec_t        tbl [6];
  logic [7:0]  exp_q [$];
  logic [7:0]  hb;
  int          ce [N];
  int unsigned b;
  int unsigned p0, p1, bp0, bh0;
  int unsigned gap_bad, cg_bad;
  logic [7:0]  d_snap;
  logic        pat [4];

  initial begin
    tbl[0] = '{2'b11, 1, 0, 1, 32'h0000_00C0};
    tbl[1] = '{2'b11, 2, 2, 4, 32'hC1C0_C1C0};
    tbl[2] = '{2'b11, 0, 2, 2, 32'h0000_C1C1};
    tbl[3] = '{2'b01, 2, 2, 2, 32'h0000_C0C0};
    tbl[4] = '{2'b10, 1, 1, 1, 32'h0000_00C1};
    tbl[5] = '{2'b11, 0, 0, 0, 32'h0000_0000};
    pat    = '{1'b1, 1'b0, 1'b0, 1'b1};
    for (int e = 0; e < N; e++) wr[e] = 8'd0;

    // Reset state, held and just after release.
    rst = 1'b1; cg = 1'b1; bp_ready = 1'b1; enable = '1;
    step();
    check("rst_valid", 32'(bp_valid), 0);
    check("rst_data",  32'(bp_data),  0);
    check("rst_pop",   32'(pop),      0);
    check("rst_busy",  32'(busy),     0);
    check("rst_grant", 32'(grant),    0);
    do_reset();
    check("rel_valid", 32'(bp_valid), 0);
    check("rel_busy",  32'(busy),     0);

    // Scenario table: FIFO contents + enable mask -> full output stream.
    for (int r = 0; r < 6; r++) begin
      do_reset();
      enable = tbl[r].en; bp_ready = 1'b1;
      b = rx.size(); p0 = pops[0]; p1 = pops[1]; bp0 = bad_pop; bh0 = bad_hold;
      for (int p = 0; p < tbl[r].n0; p++) push_pkt(0, bval(0, p, 0));
      for (int p = 0; p < tbl[r].n1; p++) push_pkt(1, bval(1, p, 0));
      exp_q.delete();
      for (int e = 0; e < N; e++) ce[e] = 0;
      for (int h = 0; h < tbl[r].nhdr; h++) begin
        hb = tbl[r].hdrs[h*8 +: 8];
        exp_q.push_back(hb);
        for (int i = 0; i < PB; i++) exp_q.push_back(bval(int'(hb[0]), ce[hb[0]], i));
        ce[hb[0]]++;
      end
      wait_rx(b, exp_q.size(), 400);
      settle(20);
      check_stream($sformatf("row%0d", r), b, exp_q);
      check($sformatf("row%0d_pops0", r), pops[0] - p0, 32'(ce[0] * PB));
      check($sformatf("row%0d_pops1", r), pops[1] - p1, 32'(ce[1] * PB));
      check($sformatf("row%0d_busy", r),  32'(busy), 0);
      check($sformatf("row%0d_popproto", r), bad_pop - bp0, 0);
      check($sformatf("row%0d_hold", r), bad_hold - bh0, 0);
    end

    // Latency: load in IDLE -> header next cycle -> first body byte the cycle after.
    do_reset();
    enable = 2'b11; bp_ready = 1'b1;
    step();
    push_pkt(0, 8'h10);
    check("lat_t0_valid", 32'(bp_valid), 0);
    check("lat_t0_busy",  32'(busy), 0);
    step();
    check("lat_t1_valid", 32'(bp_valid), 1);
    check("lat_t1_data",  32'(bp_data), 32'h00C0);
    check("lat_t1_pop",   32'(pop), 0);
    step();
    check("lat_t2_data",  32'(bp_data), 32'h0010);
    check("lat_t2_pop",   32'(pop), 32'b01);
    step();
    check("lat_t3_data",  32'(bp_data), 32'h0011);
    settle(12);
    check("lat_done_busy", 32'(busy), 0);

    // Backpressure: ready pattern 1,0,0,1 repeating over header and body.
    do_reset();
    enable = 2'b11;
    b = rx.size(); p0 = pops[0]; bp0 = bad_pop; bh0 = bad_hold;
    push_pkt(0, 8'h10);
    for (int c = 0; c < 200 && (rx.size() - b) < 9; c++) begin
      bp_ready = pat[c % 4];
      step();
    end
    bp_ready = 1'b1;
    settle(5);
    exp_q.delete();
    exp_q.push_back(8'hC0);
    for (int i = 0; i < PB; i++) exp_q.push_back(8'h10 + 8'(i));
    check_stream("bp", b, exp_q);
    check("bp_pops0", pops[0] - p0, PB);
    check("bp_hold", bad_hold - bh0, 0);
    check("bp_popproto", bad_pop - bp0, 0);

    // Clock-gate low mid-body: nothing moves, then the packet resumes intact.
    do_reset();
    enable = 2'b11; bp_ready = 1'b1;
    b = rx.size(); p0 = pops[0];
    push_pkt(0, 8'h10);
    wait_rx(b, 3, 50);
    cg = 1'b0; d_snap = bp_data; cg_bad = 0;
    for (int c = 0; c < 6; c++) begin
      step();
      if (bp_data != d_snap || pop != '0 || !bp_valid || !busy) cg_bad++;
    end
    check("cg_frozen", cg_bad, 0);
    check("cg_rx_held", rx.size() - b, 3);
    check("cg_pops_held", pops[0] - p0, 2);
    cg = 1'b1;
    wait_rx(b, 9, 50);
    settle(5);
    check_stream("cg", b, exp_q);

    // FIFO1 runs dry mid-packet; FIFO0 must wait for the packet to finish.
    do_reset();
    enable = 2'b11; bp_ready = 1'b1;
    b = rx.size(); p0 = pops[0];
    for (int i = 0; i < 3; i++) push(1, 8'hA0 + 8'(i));
    step();
    step();
    push_pkt(0, 8'h30);
    settle(6);
    gap_bad = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (bp_valid || grant != 3'd1 || !busy) gap_bad++;
    end
    step();
    check("gap_stall", gap_bad, 0);
    check("gap_fifo0_untouched", pops[0] - p0, 0);
    for (int i = 3; i < PB; i++) push(1, 8'hA0 + 8'(i));
    wait_rx(b, 18, 100);
    settle(5);
    exp_q.delete();
    exp_q.push_back(8'hC1);
    for (int i = 0; i < PB; i++) exp_q.push_back(8'hA0 + 8'(i));
    exp_q.push_back(8'hC0);
    for (int i = 0; i < PB; i++) exp_q.push_back(8'h30 + 8'(i));
    check_stream("gap", b, exp_q);

    // Enable dropped mid-body: the granted packet still completes, then IDLE.
    do_reset();
    enable = 2'b01; bp_ready = 1'b1;
    b = rx.size(); p0 = pops[0]; p1 = pops[1];
    push_pkt(0, bval(0, 0, 0));
    push_pkt(0, bval(0, 1, 0));
    push_pkt(1, bval(1, 0, 0));
    wait_rx(b, 4, 50);
    enable = 2'b00;
    settle(40);
    exp_q.delete();
    exp_q.push_back(8'hC0);
    for (int i = 0; i < PB; i++) exp_q.push_back(bval(0, 0, i));
    check_stream("endrop", b, exp_q);
    check("endrop_busy", 32'(busy), 0);
    check("endrop_pops0", pops[0] - p0, PB);
    check("endrop_pops1", pops[1] - p1, 0);

    // Reset after the fourth body byte: outputs clear at once, restart with a header.
    do_reset();
    enable = 2'b11; bp_ready = 1'b1;
    b = rx.size();
    push_pkt(0, 8'h10);
    wait_rx(b, 5, 50);
    check("mid_rst_progress", rx.size() - b, 5);
    rst = 1'b1;
    #1;
    check("mid_rst_valid", 32'(bp_valid), 0);
    check("mid_rst_data",  32'(bp_data), 0);
    check("mid_rst_pop",   32'(pop), 0);
    check("mid_rst_busy",  32'(busy), 0);
    check("mid_rst_grant", 32'(grant), 0);
    step();
    step();
    rst = 1'b0;
    push_pkt(0, 8'h60);
    b = rx.size();
    wait_rx(b, 9, 50);
    exp_q.delete();
    exp_q.push_back(8'hC0);
    for (int i = 4; i < PB; i++) exp_q.push_back(8'h10 + 8'(i));
    for (int i = 0; i < 4; i++) exp_q.push_back(8'h60 + 8'(i));
    for (int i = 0; i < exp_q.size(); i++) begin
      if (b + i < rx.size()) check($sformatf("resync_byte%0d", i), 32'(rx[b+i]), 32'(exp_q[i]));
    end
    check("resync_len", (rx.size() - b) >= 9 ? 32'd1 : 32'd0, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
